// File: rtl/sfll_hd_seq_lock.sv
// SFLL-HD output restore: a hardwired SECRET corrupts masked core outputs, a serially
// loaded key restores them. Two-stage datapath, key-load FSM and failed-commit lockout.
//
// state   | meaning
// EMPTY   | no usable key; commit here counts as a failure
// LOAD    | shifting key bits into the shadow register
// ARMED   | active key loaded, restore enabled
// LOCKOUT | too many failed commits; key interface dead until reset
module sfll_hd_seq_lock #(
    parameter int                    IN_W     = 24,
    parameter int                    NUM_OUT  = 7,
    parameter logic [NUM_OUT-1:0]    OUT_MASK = 7'b1000000,
    parameter logic [IN_W-1:0]       SECRET   = 24'h5A3C96,
    parameter int                    HD       = 0,
    parameter int                    MAX_FAIL = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_sin,
    input  logic               key_shift,
    input  logic               key_commit,
    input  logic               in_valid,
    input  logic [IN_W-1:0]    prot_in,
    input  logic [NUM_OUT-1:0] enc_out,
    output logic               out_valid,
    output logic [NUM_OUT-1:0] dout,
    output logic               key_ready,
    output logic               lock_err,
    output logic               lockout
);

    localparam int CW = $clog2(IN_W + 2);
    localparam int PW = $clog2(IN_W + 1);

    typedef enum logic [1:0] {EMPTY, LOAD, ARMED, LOCKOUT} state_t;

    state_t             state_q, state_d;
    logic [IN_W-1:0]    shadow_q, shadow_d;
    logic [IN_W-1:0]    active_q, active_d;
    logic [CW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [3:0]         fail_cnt_q, fail_cnt_d;
    logic               key_ready_q, key_ready_d;
    logic               lock_err_q, lock_err_d;
    logic               lockout_q, lockout_d;

    logic               v1_q, v1_d;
    logic [IN_W-1:0]    p1_q, p1_d;
    logic [NUM_OUT-1:0] e1_q, e1_d;
    logic               out_valid_q, out_valid_d;
    logic [NUM_OUT-1:0] dout_q, dout_d;
    logic               flip, rest;

    function automatic logic [PW-1:0] popcnt(input logic [IN_W-1:0] v);
        logic [PW-1:0] c;
        c = '0;
        for (int i = 0; i < IN_W; i++) c = c + PW'(v[i]);
        return c;
    endfunction

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        active_d    = active_q;
        bit_cnt_d   = bit_cnt_q;
        fail_cnt_d  = fail_cnt_q;
        key_ready_d = key_ready_q;
        lock_err_d  = lock_err_q;
        lockout_d   = lockout_q;
        if (state_q == LOCKOUT) begin
            key_ready_d = 1'b0;
            lockout_d   = 1'b1;
        end else if (key_shift) begin
            // a shift always wins over a same-cycle commit
            shadow_d    = {shadow_q[IN_W-2:0], key_sin};
            bit_cnt_d   = (bit_cnt_q == CW'(IN_W + 1)) ? bit_cnt_q : bit_cnt_q + 1'b1;
            key_ready_d = 1'b0;
            state_d     = LOAD;
        end else if (key_commit) begin
            if (bit_cnt_q == CW'(IN_W)) begin
                active_d    = shadow_q;
                bit_cnt_d   = '0;
                key_ready_d = 1'b1;
                state_d     = ARMED;
            end else if (state_q != ARMED) begin
                bit_cnt_d   = '0;
                lock_err_d  = 1'b1;
                fail_cnt_d  = fail_cnt_q + 1'b1;
                key_ready_d = 1'b0;
                if (fail_cnt_d == 4'(MAX_FAIL)) begin
                    state_d   = LOCKOUT;
                    lockout_d = 1'b1;
                end else begin
                    state_d = EMPTY;
                end
            end
        end
    end

    always_comb begin
        v1_d        = in_valid;
        p1_d        = prot_in;
        e1_d        = enc_out;
        // flip and restore cancel when the active key equals SECRET
        flip        = (popcnt(p1_q ^ SECRET) == PW'(HD));
        rest        = key_ready_q & (popcnt(p1_q ^ active_q) == PW'(HD));
        out_valid_d = v1_q;
        dout_d      = v1_q ? (e1_q ^ ({NUM_OUT{flip ^ rest}} & OUT_MASK)) : dout_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            shadow_q    <= '0;
            active_q    <= '0;
            bit_cnt_q   <= '0;
            fail_cnt_q  <= '0;
            key_ready_q <= 1'b0;
            lock_err_q  <= 1'b0;
            lockout_q   <= 1'b0;
            v1_q        <= 1'b0;
            p1_q        <= '0;
            e1_q        <= '0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            bit_cnt_q   <= bit_cnt_d;
            fail_cnt_q  <= fail_cnt_d;
            key_ready_q <= key_ready_d;
            lock_err_q  <= lock_err_d;
            lockout_q   <= lockout_d;
            v1_q        <= v1_d;
            p1_q        <= p1_d;
            e1_q        <= e1_d;
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
        end
    end

    assign out_valid = out_valid_q;
    assign dout      = dout_q;
    assign key_ready = key_ready_q;
    assign lock_err  = lock_err_q;
    assign lockout   = lockout_q;

endmodule

// File: tb/tb_sfll_hd_seq_lock.sv
// Bench for sfll_hd_seq_lock: directed key-load scenarios plus random traffic, checked
// against a behavioural model; a second HD=2 instance shares the same stimulus.
module tb_sfll_hd_seq_lock;
    localparam logic [23:0] SECRET = 24'h5A3C96;
    localparam logic [6:0]  MASK   = 7'b1000000;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        key_sin = 0, key_shift = 0, key_commit = 0, in_valid = 0;
    logic [23:0] prot_in = '0;
    logic [6:0]  enc_out = '0;
    logic        out_valid, key_ready, lock_err, lockout;
    logic [6:0]  dout;
    logic        out_valid2, key_ready2, lock_err2, lockout2;
    logic [6:0]  dout2;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    logic [23:0] m_shadow, m_act, m_p1;
    logic [6:0]  m_e1, m_dout, m_dout2;
    int          m_cnt, m_fail;
    logic        m_ready, m_err, m_lock, m_armed, m_v1, m_ov;

    sfll_hd_seq_lock dut (
        .clk(clk), .rst_n(rst_n), .key_sin(key_sin), .key_shift(key_shift),
        .key_commit(key_commit), .in_valid(in_valid), .prot_in(prot_in), .enc_out(enc_out),
        .out_valid(out_valid), .dout(dout), .key_ready(key_ready), .lock_err(lock_err),
        .lockout(lockout)
    );

    sfll_hd_seq_lock #(.HD(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .key_sin(key_sin), .key_shift(key_shift),
        .key_commit(key_commit), .in_valid(in_valid), .prot_in(prot_in), .enc_out(enc_out),
        .out_valid(out_valid2), .dout(dout2), .key_ready(key_ready2), .lock_err(lock_err2),
        .lockout(lockout2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] restore(input logic [23:0] p, input logic [6:0] e,
                                           input logic [23:0] act, input logic rdy, input int hd);
        logic f, r;
        f = ($countones(p ^ SECRET) == hd);
        r = rdy && ($countones(p ^ act) == hd);
        return (f != r) ? (e ^ MASK) : e;
    endfunction

    task automatic model_reset();
        m_shadow = '0; m_act = '0; m_p1 = '0; m_e1 = '0; m_dout = '0; m_dout2 = '0;
        m_cnt = 0; m_fail = 0; m_ready = 0; m_err = 0; m_lock = 0; m_armed = 0;
        m_v1 = 0; m_ov = 0;
    endtask

    task automatic model_edge();
        if (m_v1) begin
            m_dout  = restore(m_p1, m_e1, m_act, m_ready, 0);
            m_dout2 = restore(m_p1, m_e1, m_act, m_ready, 2);
        end
        m_ov = m_v1;
        m_v1 = in_valid; m_p1 = prot_in; m_e1 = enc_out;
        if (!m_lock) begin
            if (key_shift) begin
                m_shadow = {m_shadow[22:0], key_sin};
                m_cnt    = (m_cnt >= 25) ? 25 : m_cnt + 1;
                m_ready  = 0;
                m_armed  = 0;
            end else if (key_commit) begin
                if (m_cnt == 24) begin
                    m_act = m_shadow; m_cnt = 0; m_ready = 1; m_armed = 1;
                end else if (!m_armed) begin
                    m_cnt = 0; m_err = 1; m_fail++; m_ready = 0;
                    if (m_fail == 3) m_lock = 1;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out_valid"}, out_valid, m_ov);
        chk({tag, ".dout"}, dout, m_dout);
        chk({tag, ".key_ready"}, key_ready, m_ready);
        chk({tag, ".lock_err"}, lock_err, m_err);
        chk({tag, ".lockout"}, lockout, m_lock);
        chk({tag, ".dout_hd2"}, dout2, m_dout2);
    endtask

    // inputs are driven 1 time unit after a posedge; outputs sampled 1 unit after the next
    task automatic cyc(input logic sh, input logic sin, input logic cm, input logic v,
                       input logic [23:0] p, input logic [6:0] e, input string tag);
        key_shift = sh; key_sin = sin; key_commit = cm; in_valid = v; prot_in = p; enc_out = e;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, '0, '0, "idle");
    endtask

    task automatic do_reset();
        key_shift = 0; key_commit = 0; in_valid = 0;
        rst_n = 0;
        #3;
        model_reset();
        chk("rst.out_valid", out_valid, 1'b0);
        chk("rst.dout", dout, 7'h00);
        chk("rst.key_ready", key_ready, 1'b0);
        chk("rst.lock_err", lock_err, 1'b0);
        chk("rst.lockout", lockout, 1'b0);
        rst_n = 1;
    endtask

    task automatic load_key(input logic [23:0] k, input int nbits);
        for (int i = 0; i < nbits; i++) cyc(1, k[23-i], 0, 0, '0, '0, "shift");
    endtask

    task automatic data(input logic [23:0] p, input logic [6:0] e, input string tag);
        cyc(0, 0, 0, 1, p, e, tag);
        idle(2);
    endtask

    task automatic rand_traffic(input int n);
        logic [23:0] p;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 4))
                0: p = SECRET;
                1: p = m_act;
                2: p = SECRET ^ (24'h1 << $urandom_range(0, 23));
                3: p = SECRET ^ (24'h3 << $urandom_range(0, 22));
                default: p = 24'($urandom);
            endcase
            cyc(0, 0, 0, ($urandom_range(0, 3) != 0), p, 7'($urandom), "rand");
        end
    endtask

    initial begin
        model_reset();
        @(posedge clk); #1;
        do_reset();
        idle(1);

        // no key: corruption visible on SECRET only
        data(SECRET, 7'h00, "nokey_secret");
        chk("nokey_secret.const", dout, 7'h40);
        data(24'h000001, 7'h15, "nokey_other");
        chk("nokey_other.const", dout, 7'h15);
        rand_traffic(20);

        // reset mid-shift discards partial key; 23 more shifts are not enough
        load_key(SECRET, 10);
        do_reset();
        load_key(SECRET, 23);
        cyc(0, 0, 1, 0, '0, '0, "commit23");
        chk("commit23.lock_err", lock_err, 1'b1);
        chk("commit23.key_ready", key_ready, 1'b0);
        do_reset();

        // correct key: flip and restore cancel
        load_key(SECRET, 24);
        cyc(0, 0, 1, 0, '0, '0, "commit_secret");
        chk("commit_secret.key_ready", key_ready, 1'b1);
        data(SECRET, 7'h40, "key_secret");
        chk("key_secret.const", dout, 7'h40);
        data(SECRET ^ 24'h000003, 7'h2A, "hd2_dist2");
        chk("hd2_dist2.const", dout2, 7'h2A);
        data(SECRET ^ 24'h000001, 7'h2B, "hd2_dist1");
        chk("hd2_dist1.const", dout2, 7'h2B);
        cyc(0, 0, 1, 0, '0, '0, "commit_noop");
        chk("commit_noop.lock_err", lock_err, 1'b0);
        rand_traffic(40);

        // wrong key restores the wrong pattern
        load_key(24'h000001, 24);
        cyc(0, 0, 1, 0, '0, '0, "commit_wrong");
        data(24'h000001, 7'h15, "wrong_key");
        chk("wrong_key.const", dout, 7'h55);
        rand_traffic(40);

        // shift with same-cycle commit: commit ignored, 25 bits then over-shifted
        load_key(SECRET, 23);
        cyc(1, 0, 1, 0, '0, '0, "shift_commit");
        chk("shift_commit.lock_err", lock_err, 1'b0);
        cyc(1, 1, 0, 0, '0, '0, "overshift");
        cyc(0, 0, 1, 0, '0, '0, "commit_over");
        chk("commit_over.lock_err", lock_err, 1'b1);

        // repeated short loads drive into lockout
        load_key(SECRET, 23);
        cyc(0, 0, 1, 0, '0, '0, "fail2");
        chk("fail2.lockout", lockout, 1'b0);
        load_key(SECRET, 23);
        cyc(0, 0, 1, 0, '0, '0, "fail3");
        chk("fail3.lockout", lockout, 1'b1);
        load_key(SECRET, 24);
        cyc(0, 0, 1, 0, '0, '0, "locked_commit");
        chk("locked_commit.key_ready", key_ready, 1'b0);
        data(SECRET, 7'h00, "locked_secret");
        chk("locked_secret.const", dout, 7'h40);
        rand_traffic(30);

        do_reset();
        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
